// File: rtl/hls_deadlock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hls_deadlock_pkg
// Description : Shared FSM state encoding and sizing helpers for the
//               HLS deadlock watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
package hls_deadlock_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle     = 2'd0;
    localparam state_t c_st_suspect  = 2'd1;
    localparam state_t c_st_deadlock = 2'd2;

    // Index width for an n-input blocker vector; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hls_deadlock_watchdog_if.sv
`default_nettype none
// ============================================================================
// Module      : hls_deadlock_watchdog_if
// Description : Block-flag inputs and status outputs of the deadlock watchdog.
//               blocked_snapshot exists only with HLS_DEADLOCK_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface hls_deadlock_watchdog_if
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = 5,
    parameter int NUM_SUB  = 2,
    parameter int CNT_W    = 8,
    parameter int IDX_W    = idx_width(NUM_AXIS + NUM_SUB)
);

    logic [NUM_AXIS-1:0]         axis_block_sigs;
    logic [NUM_SUB-1:0]          sub_block_sigs;
    logic                        clear;
    logic                        block;
    logic                        deadlock;
    logic [CNT_W-1:0]            block_cycles;
    logic [IDX_W-1:0]            first_idx;
`ifdef HLS_DEADLOCK_TRACE_EN
    logic [NUM_AXIS+NUM_SUB-1:0] blocked_snapshot;
`endif

    modport master (
        output axis_block_sigs,
        output sub_block_sigs,
        output clear,
        input  block,
        input  deadlock,
        input  block_cycles,
        input  first_idx
`ifdef HLS_DEADLOCK_TRACE_EN
        , input blocked_snapshot
`endif
    );

    modport slave (
        input  axis_block_sigs,
        input  sub_block_sigs,
        input  clear,
        output block,
        output deadlock,
        output block_cycles,
        output first_idx
`ifdef HLS_DEADLOCK_TRACE_EN
        , output blocked_snapshot
`endif
    );

endinterface
`default_nettype wire

// File: rtl/hls_deadlock_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : hls_deadlock_prio_enc
// Description : Lowest-set-bit priority encoder, parametrised by input width.
// Revision    : 1.0 - initial release
// ============================================================================
module hls_deadlock_prio_enc #(
    parameter int WIDTH = 7,
    parameter int IDX_W = 3
) (
    input  wire logic [WIDTH-1:0] i_req,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_valid
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hls_deadlock_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : hls_deadlock_watchdog
// Description : Flags a deadlock after WINDOW consecutive blocked cycles across
//               AXIS and child-monitor block flags; sticky until clear.
//               HLS_DEADLOCK_TRACE_EN adds first-blocker and snapshot capture.
// Revision    : 1.0 - initial release
// ============================================================================
module hls_deadlock_watchdog
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = 5,
    parameter int NUM_SUB  = 2,
    parameter int WINDOW   = 16,
    parameter int CNT_W    = 8
) (
    input wire logic               clock,
    input wire logic               reset_n,
    hls_deadlock_watchdog_if.slave bus
);

    localparam int               c_num_in  = NUM_AXIS + NUM_SUB;
    localparam int               c_idx_w   = idx_width(c_num_in);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_window  = CNT_W'(WINDOW);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                r_block;
    logic                w_raw_block;
    logic                w_deadlock;
    logic [c_num_in-1:0] w_all_sigs;

    assign w_all_sigs  = {bus.sub_block_sigs, bus.axis_block_sigs};
    assign w_raw_block = |w_all_sigs;
    assign w_cnt_inc   = r_cnt + c_cnt_one;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_block <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_block <= w_raw_block;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (bus.clear) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_raw_block) begin
                        w_state_nxt = (WINDOW == 1) ? c_st_deadlock : c_st_suspect;
                        w_cnt_nxt   = c_cnt_one;
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                c_st_suspect: begin
                    if (!w_raw_block) begin
                        w_state_nxt = c_st_idle;
                        w_cnt_nxt   = '0;
                    end else begin
                        if (w_cnt_inc == c_window) begin
                            w_state_nxt = c_st_deadlock;
                        end
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                c_st_deadlock: begin
                    // Run length keeps growing for diagnostics, pinned at all-ones.
                    if (w_raw_block && (r_cnt != c_cnt_max)) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_deadlock = 1'b0;
        if (r_state == c_st_deadlock) begin
            w_deadlock = 1'b1;
        end
    end

    assign bus.block        = r_block;
    assign bus.deadlock     = w_deadlock;
    assign bus.block_cycles = r_cnt;

`ifdef HLS_DEADLOCK_TRACE_EN
    logic                w_enter;
    logic [c_idx_w-1:0]  w_low_idx;
    logic                w_low_valid;
    logic [c_idx_w-1:0]  r_first_idx;
    logic [c_num_in-1:0] r_snapshot;

    assign w_enter = (r_state != c_st_deadlock) && (w_state_nxt == c_st_deadlock);

    hls_deadlock_prio_enc #(
        .WIDTH (c_num_in),
        .IDX_W (c_idx_w)
    ) u_prio_enc (
        .i_req   (w_all_sigs),
        .o_idx   (w_low_idx),
        .o_valid (w_low_valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_first_idx <= '0;
            r_snapshot  <= '0;
        end else if (bus.clear) begin
            r_first_idx <= '0;
            r_snapshot  <= '0;
        end else if (w_enter) begin
            r_first_idx <= w_low_valid ? w_low_idx : '0;
            r_snapshot  <= w_all_sigs;
        end
    end

    assign bus.first_idx        = r_first_idx;
    assign bus.blocked_snapshot = r_snapshot;
`else
    assign bus.first_idx = '0;
`endif

endmodule
`default_nettype wire

// File: doc/hls_deadlock_watchdog.md
HLS_DEADLOCK_WATCHDOG -- requirements
Module: hls_deadlock_watchdog

Interface
REQ-001 Parameter NUM_AXIS, 5, number of AXIS channel block inputs; channel 0 is the monitored instance's own stream.
REQ-002 Parameter NUM_SUB, 2, number of child-monitor block inputs (sub-instance monitors).
REQ-003 Parameter WINDOW, 16, consecutive blocked cycles required to declare deadlock; range 1..2^CNT_W-1.
REQ-004 Parameter CNT_W, 8, width of the persistence and blocked-cycle counters.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 axis_block_sigs  input  NUM_AXIS  per-channel AXIS blocked flags.
REQ-008 sub_block_sigs  input  NUM_SUB  block outputs of child monitors.
REQ-009 clear  input  1  synchronous release of the sticky deadlock state.
REQ-010 block  output  1  registered raw block indication, one cycle behind inputs.
REQ-011 deadlock  output  1  sticky deadlock flag.
REQ-012 block_cycles  output  CNT_W  current consecutive-block run length, saturating.
REQ-013 first_idx  output  $clog2(NUM_AXIS+NUM_SUB)  lowest-index blocker latched at deadlock entry.

Function
REQ-014 raw_block SHALL be the OR of all axis_block_sigs bits and all sub_block_sigs bits.
REQ-015 block SHALL equal raw_block registered, 1-cycle latency.
REQ-016 FSM SHALL have states IDLE, SUSPECT, DEADLOCK.
REQ-017 IDLE: raw_block=1 -> SUSPECT, counter loads 1; else stay, counter 0.
REQ-018 SUSPECT: raw_block=0 -> IDLE, counter 0; raw_block=1 and counter+1 == WINDOW -> DEADLOCK; else counter increments.
REQ-019 WINDOW=1 SHALL pass IDLE->DEADLOCK directly on the first blocked cycle.
REQ-020 DEADLOCK: deadlock=1 regardless of raw_block; counter keeps incrementing while raw_block=1, saturating at 2^CNT_W-1, and holds when raw_block=0.
REQ-021 DEADLOCK exits only on clear=1 -> IDLE, counter 0, deadlock 0 next cycle.
REQ-022 clear in IDLE or SUSPECT SHALL force IDLE with counter 0; clear takes priority over a simultaneous raw_block.
REQ-023 block_cycles SHALL present the counter register directly.
REQ-024 first_idx SHALL latch, on the DEADLOCK-entry cycle, the lowest set index of the concatenation {sub_block_sigs, axis_block_sigs} (axis bits indices 0..NUM_AXIS-1, sub bits following); it holds until clear.
REQ-025 Inputs SHALL be treated as synchronous to clock; no synchronisers inside.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, block 0, deadlock 0, block_cycles 0, first_idx 0.
REQ-027 Reset assertion mid-SUSPECT or in DEADLOCK SHALL discard all progress; deassertion resumes from IDLE on the next edge.

Configuration
REQ-028 With HLS_DEADLOCK_TRACE_EN defined, first_idx capture per REQ-024 and a NUM_AXIS+NUM_SUB-bit snapshot register (output blocked_snapshot) latched at DEADLOCK entry SHALL be present.
REQ-029 Without HLS_DEADLOCK_TRACE_EN, first_idx SHALL be tied 0, blocked_snapshot absent, and FSM/counter behaviour identical.

Structure
REQ-030 FSM state encoding typedef and state constants SHALL live in the shared package hls_deadlock_pkg.
REQ-031 The lowest-set-bit priority encoder SHALL be one sub-module, hls_deadlock_prio_enc, parametrised by input width.
REQ-032 No other sub-modules; counter and FSM reside in the top.

Verification
REQ-033 WINDOW=4, axis_block_sigs=5'b00100 held 4 cycles -> deadlock=1 on the cycle after the 4th blocked edge, first_idx=2.
REQ-034 WINDOW=4, block 3 cycles then 0 -> deadlock stays 0, block_cycles returns 0, state IDLE.
REQ-035 In DEADLOCK, block held 300 cycles with CNT_W=8 -> block_cycles saturates at 255, deadlock stays 1.
REQ-036 sub_block_sigs=2'b10 only, WINDOW=1 -> deadlock=1 after one cycle, first_idx=6; clear pulse -> deadlock=0, first_idx=0 next cycle.
REQ-037 reset_n pulsed low asynchronously mid-SUSPECT (block_cycles=3) -> all outputs 0 immediately, no clock edge required.
REQ-038 Both macro settings run REQ-033..REQ-037; FSM outputs match cycle-for-cycle, first_idx 0 when macro undefined.
